// File: rtl/alu_issue_ctrl_pkg.sv
// Shared types and constants for the ALU issue controller: FSM states,
// opcode/opext encodings, instruction field positions and PSR flag indices.
package alu_issue_ctrl_pkg;

  localparam int unsigned INSTR_W = 16;
  localparam int unsigned DATA_W  = 16;
  localparam int unsigned REG_AW  = 4;
  localparam int unsigned FLAG_W  = 5;
  localparam int unsigned FIELD_W = 4;
  localparam int unsigned IMM8_W  = 8;

  localparam int unsigned OPC_HI = 15;
  localparam int unsigned OPC_LO = 12;
  localparam int unsigned RD_HI  = 11;
  localparam int unsigned RD_LO  = 8;
  localparam int unsigned EXT_HI = 7;
  localparam int unsigned EXT_LO = 4;
  localparam int unsigned RS_HI  = 3;
  localparam int unsigned RS_LO  = 0;
  localparam int unsigned IMM_HI = 7;
  localparam int unsigned IMM_LO = 0;

  localparam int unsigned FLAG_C = 4;
  localparam int unsigned FLAG_L = 3;
  localparam int unsigned FLAG_F = 2;
  localparam int unsigned FLAG_Z = 1;
  localparam int unsigned FLAG_N = 0;

  localparam logic [FIELD_W-1:0] OPC_REG   = 4'b0000;
  localparam logic [FIELD_W-1:0] OPC_ADDI  = 4'b0101;
  localparam logic [FIELD_W-1:0] OPC_ADDUI = 4'b0110;
  localparam logic [FIELD_W-1:0] OPC_ADDCI = 4'b0111;
  localparam logic [FIELD_W-1:0] OPC_SHIFT = 4'b1010;

  localparam logic [FIELD_W-1:0] EXT_AND    = 4'b0001;
  localparam logic [FIELD_W-1:0] EXT_ADD    = 4'b0101;
  localparam logic [FIELD_W-1:0] EXT_ADDU   = 4'b0110;
  localparam logic [FIELD_W-1:0] EXT_ADDC   = 4'b0111;
  localparam logic [FIELD_W-1:0] EXT_SH_REG = 4'b0101;
  localparam logic [FIELD_W-1:0] EXT_SH_IMM = 4'b0110;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DECODE = 2'd1,
    ST_EXEC   = 2'd2,
    ST_WB     = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    IMM_NONE = 2'd0,
    IMM_LO8  = 2'd1,
    IMM_LO4  = 2'd2
  } imm_sel_e;

  function automatic logic [FIELD_W-1:0] f_opc(input logic [INSTR_W-1:0] i);
    return i[OPC_HI:OPC_LO];
  endfunction

  function automatic logic [FIELD_W-1:0] f_ext(input logic [INSTR_W-1:0] i);
    return i[EXT_HI:EXT_LO];
  endfunction

  function automatic logic [REG_AW-1:0] f_rd(input logic [INSTR_W-1:0] i);
    return i[RD_HI:RD_LO];
  endfunction

  function automatic logic [REG_AW-1:0] f_rs(input logic [INSTR_W-1:0] i);
    return i[RS_HI:RS_LO];
  endfunction

  function automatic logic [IMM8_W-1:0] f_imm8(input logic [INSTR_W-1:0] i);
    return i[IMM_HI:IMM_LO];
  endfunction

endpackage

// File: rtl/alu_issue_decode.sv
// Combinational instruction classifier: legality plus immediate operand form.
module alu_issue_decode
  import alu_issue_ctrl_pkg::*;
(
  input  logic [3:0] opcode,
  input  logic [3:0] opext,
  output logic       legal,
  output logic [1:0] imm_sel,
  output logic       sign_ext
);

  always_comb begin
    legal    = 1'b0;
    imm_sel  = IMM_NONE;
    sign_ext = 1'b0;
    case (opcode)
      OPC_REG: begin
        legal = (opext == EXT_AND) || (opext == EXT_ADD) ||
                (opext == EXT_ADDU) || (opext == EXT_ADDC);
      end
      OPC_ADDI, OPC_ADDCI: begin
        legal    = 1'b1;
        imm_sel  = IMM_LO8;
        sign_ext = 1'b1;
      end
      OPC_ADDUI: begin
        legal   = 1'b1;
        imm_sel = IMM_LO8;
      end
      OPC_SHIFT: begin
        if (opext == EXT_SH_REG) begin
          legal = 1'b1;
        end else if (opext == EXT_SH_IMM) begin
          legal   = 1'b1;
          imm_sel = IMM_LO4;
        end
      end
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Four-state issue controller: accepts an instruction, reads operands, drives
// the external ALU, then writes the result and flags back.
module alu_issue_ctrl
  import alu_issue_ctrl_pkg::*;
#(
  parameter logic [4:0] PSR_RST = 5'b00000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [15:0] instr,
  output logic [3:0]  rf_raddr_a,
  output logic [3:0]  rf_raddr_b,
  input  logic [15:0] rf_rdata_a,
  input  logic [15:0] rf_rdata_b,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic [3:0]  alu_opcode,
  output logic [3:0]  alu_opext,
  output logic        alu_carry,
  input  logic [15:0] alu_s,
  input  logic [4:0]  alu_clfzn,
  output logic        rf_we,
  output logic [3:0]  rf_waddr,
  output logic [15:0] rf_wdata,
  output logic [4:0]  psr,
  output logic        illegal,
  output logic        busy
);

  state_e              state_q, state_d;
  logic [INSTR_W-1:0]  instr_q, instr_d;
  logic [REG_AW-1:0]   raddr_a_q, raddr_a_d;
  logic [REG_AW-1:0]   raddr_b_q, raddr_b_d;
  logic [DATA_W-1:0]   res_q, res_d;
  logic [FLAG_W-1:0]   flags_q, flags_d;
  logic [FLAG_W-1:0]   psr_q, psr_d;
  logic [REG_AW-1:0]   rf_waddr_q, rf_waddr_d;
  logic                rf_we_q, rf_we_d;
  logic                illegal_q, illegal_d;
  logic                ready_q, ready_d;
  logic                busy_q, busy_d;

  logic                dec_legal;
  logic [1:0]          dec_imm_sel;
  logic                dec_sign_ext;

  alu_issue_decode u_decode (
    .opcode   (f_opc(instr_q)),
    .opext    (f_ext(instr_q)),
    .legal    (dec_legal),
    .imm_sel  (dec_imm_sel),
    .sign_ext (dec_sign_ext)
  );

  // Next-state and registered-output logic.
  always_comb begin
    state_d    = state_q;
    instr_d    = instr_q;
    raddr_a_d  = raddr_a_q;
    raddr_b_d  = raddr_b_q;
    res_d      = res_q;
    flags_d    = flags_q;
    psr_d      = psr_q;
    rf_waddr_d = rf_waddr_q;
    rf_we_d    = 1'b0;
    illegal_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (instr_valid && ready_q) begin
          state_d   = ST_DECODE;
          instr_d   = instr;
          raddr_a_d = f_rd(instr);
          raddr_b_d = f_rs(instr);
        end
      end
      ST_DECODE: begin
        if (dec_legal) begin
          state_d = ST_EXEC;
        end else begin
          state_d   = ST_IDLE;
          illegal_d = 1'b1;
        end
      end
      ST_EXEC: begin
        state_d    = ST_WB;
        res_d      = alu_s;
        flags_d    = alu_clfzn;
        rf_we_d    = 1'b1;
        rf_waddr_d = f_rd(instr_q);
      end
      ST_WB: begin
        state_d = ST_IDLE;
        psr_d   = flags_q;
      end
      default: state_d = ST_IDLE;
    endcase
    ready_d = (state_d == ST_IDLE);
    busy_d  = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      instr_q    <= '0;
      raddr_a_q  <= '0;
      raddr_b_q  <= '0;
      res_q      <= '0;
      flags_q    <= '0;
      psr_q      <= PSR_RST;
      rf_waddr_q <= '0;
      rf_we_q    <= 1'b0;
      illegal_q  <= 1'b0;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      instr_q    <= instr_d;
      raddr_a_q  <= raddr_a_d;
      raddr_b_q  <= raddr_b_d;
      res_q      <= res_d;
      flags_q    <= flags_d;
      psr_q      <= psr_d;
      rf_waddr_q <= rf_waddr_d;
      rf_we_q    <= rf_we_d;
      illegal_q  <= illegal_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
    end
  end

  // ALU operands follow the register file read data the cycle it arrives.
  always_comb begin
    alu_a      = '0;
    alu_b      = '0;
    alu_opcode = '0;
    alu_opext  = '0;
    alu_carry  = 1'b0;
    if (state_q == ST_EXEC) begin
      alu_a      = rf_rdata_a;
      alu_opcode = f_opc(instr_q);
      alu_opext  = f_ext(instr_q);
      alu_carry  = psr_q[FLAG_C];
      case (dec_imm_sel)
        IMM_LO8: alu_b = dec_sign_ext ? DATA_W'($signed(f_imm8(instr_q)))
                                      : DATA_W'(f_imm8(instr_q));
        IMM_LO4: alu_b = DATA_W'(f_rs(instr_q));
        default: alu_b = rf_rdata_b;
      endcase
    end
  end

  assign instr_ready = ready_q;
  assign busy        = busy_q;
  assign illegal     = illegal_q;
  assign rf_raddr_a  = raddr_a_q;
  assign rf_raddr_b  = raddr_b_q;
  assign rf_we       = rf_we_q;
  assign rf_waddr    = rf_waddr_q;
  assign rf_wdata    = res_q;
  assign psr         = psr_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural register file and ALU.
module tb_alu_issue_ctrl;

  logic        clk;
  logic        rst_n;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;
  logic [3:0]  rf_raddr_a, rf_raddr_b;
  logic [15:0] rf_rdata_a, rf_rdata_b;
  logic [15:0] alu_a, alu_b;
  logic [3:0]  alu_opcode, alu_opext;
  logic        alu_carry;
  logic [15:0] alu_s;
  logic [4:0]  alu_clfzn;
  logic        rf_we;
  logic [3:0]  rf_waddr;
  logic [15:0] rf_wdata;
  logic [4:0]  psr;
  logic        illegal;
  logic        busy;

  logic [15:0] regs [16];
  logic        tb_we;
  logic [3:0]  tb_waddr;
  logic [15:0] tb_wdata;

  int n_vec;
  int n_miss;

  alu_issue_ctrl #(.PSR_RST(5'b00000)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .rf_raddr_a  (rf_raddr_a),
    .rf_raddr_b  (rf_raddr_b),
    .rf_rdata_a  (rf_rdata_a),
    .rf_rdata_b  (rf_rdata_b),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_opcode  (alu_opcode),
    .alu_opext   (alu_opext),
    .alu_carry   (alu_carry),
    .alu_s       (alu_s),
    .alu_clfzn   (alu_clfzn),
    .rf_we       (rf_we),
    .rf_waddr    (rf_waddr),
    .rf_wdata    (rf_wdata),
    .psr         (psr),
    .illegal     (illegal),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file with one-cycle read latency.
  always @(posedge clk) begin
    rf_rdata_a <= regs[rf_raddr_a];
    rf_rdata_b <= regs[rf_raddr_b];
    if (rf_we) regs[rf_waddr] <= rf_wdata;
    else if (tb_we) regs[tb_waddr] <= tb_wdata;
  end

  // Adds (with carry for ADDC/ADDCI), AND, and shift-left for opcode 1010.
  function automatic logic [20:0] alu_model(input logic [15:0] a, input logic [15:0] b,
                                            input logic [3:0] opc, input logic [3:0] ext,
                                            input logic cin);
    logic [16:0] sum;
    logic [15:0] s;
    logic [4:0]  fl;
    logic        use_c;
    fl    = 5'b00000;
    use_c = (opc == 4'h7) || (opc == 4'h0 && ext == 4'h7);
    if (opc == 4'h0 && ext == 4'h1) begin
      s = a & b;
    end else if (opc == 4'hA) begin
      s = a << b[3:0];
    end else begin
      sum   = {1'b0, a} + {1'b0, b} + 17'(use_c & cin);
      s     = sum[15:0];
      fl[4] = sum[16];
      fl[2] = (a[15] == b[15]) && (s[15] != a[15]);
      fl[1] = (s == 16'h0000);
    end
    return {fl, s};
  endfunction

  always_comb {alu_clfzn, alu_s} = alu_model(alu_a, alu_b, alu_opcode, alu_opext, alu_carry);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic poke(input logic [3:0] a, input logic [15:0] d);
    tb_we    = 1'b1;
    tb_waddr = a;
    tb_wdata = d;
    @(negedge clk);
    tb_we    = 1'b0;
  endtask

  // Starts at a negedge in IDLE; samples each of DECODE, EXEC, WB and the next IDLE.
  task automatic run_op(input string tag, input logic [15:0] ins, input logic [15:0] ea,
                        input logic [15:0] eb, input logic ecy, input logic [15:0] ew,
                        input logic [4:0] ep);
    instr_valid = 1'b1;
    instr       = ins;
    check({tag, " ready"}, 32'(instr_ready), 32'd1);
    @(negedge clk);
    instr_valid = 1'b0;
    check({tag, " busy"}, 32'(busy), 32'd1);
    check({tag, " raddr_a"}, 32'(rf_raddr_a), 32'(ins[11:8]));
    @(negedge clk);
    check({tag, " alu_a"}, 32'(alu_a), 32'(ea));
    check({tag, " alu_b"}, 32'(alu_b), 32'(eb));
    check({tag, " alu_carry"}, 32'(alu_carry), 32'(ecy));
    check({tag, " alu_opcode"}, 32'(alu_opcode), 32'(ins[15:12]));
    @(negedge clk);
    check({tag, " rf_we"}, 32'(rf_we), 32'd1);
    check({tag, " rf_waddr"}, 32'(rf_waddr), 32'(ins[11:8]));
    check({tag, " rf_wdata"}, 32'(rf_wdata), 32'(ew));
    @(negedge clk);
    check({tag, " rf_we_off"}, 32'(rf_we), 32'd0);
    check({tag, " psr"}, 32'(psr), 32'(ep));
    check({tag, " ready_back"}, 32'(instr_ready), 32'd1);
  endtask

  task automatic run_illegal(input string tag, input logic [15:0] ins, input logic [4:0] ep);
    instr_valid = 1'b1;
    instr       = ins;
    check({tag, " ready"}, 32'(instr_ready), 32'd1);
    @(negedge clk);
    instr_valid = 1'b0;
    check({tag, " busy"}, 32'(busy), 32'd1);
    @(negedge clk);
    check({tag, " illegal"}, 32'(illegal), 32'd1);
    check({tag, " ready"}, 32'(instr_ready), 32'd1);
    check({tag, " rf_we"}, 32'(rf_we), 32'd0);
    check({tag, " busy_off"}, 32'(busy), 32'd0);
    @(negedge clk);
    check({tag, " illegal_off"}, 32'(illegal), 32'd0);
    check({tag, " psr"}, 32'(psr), 32'(ep));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    n_vec       = 0;
    n_miss      = 0;
    rst_n       = 1'b0;
    instr_valid = 1'b0;
    instr       = 16'h0000;
    tb_we       = 1'b0;
    tb_waddr    = 4'h0;
    tb_wdata    = 16'h0000;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      poke(4'(i), 16'h0000);
    end
    check("rst psr", 32'(psr), 32'h00);
    check("rst rf_we", 32'(rf_we), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst illegal", 32'(illegal), 32'd0);
    check("rst alu_a", 32'(alu_a), 32'h0);
    rst_n = 1'b1;
    check("rst ready", 32'(instr_ready), 32'd1);
    @(negedge clk);

    poke(4'd1, 16'h7FFF);
    poke(4'd2, 16'h0001);
    run_op("ADD", 16'h0152, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 5'b00100);
    check("ADD R1", 32'(regs[1]), 32'h8000);

    poke(4'd3, 16'hFFFF);
    run_op("ADDUI", 16'h6301, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 5'b10010);

    poke(4'd4, 16'h0001);
    poke(4'd5, 16'h0001);
    run_op("ADDC", 16'h0475, 16'h0001, 16'h0001, 1'b1, 16'h0003, 5'b00000);
    check("ADDC R4", 32'(regs[4]), 32'h0003);

    poke(4'd6, 16'h0001);
    run_op("ADDI", 16'h56FF, 16'h0001, 16'hFFFF, 1'b0, 16'h0000, 5'b10010);

    run_illegal("ILL_F000", 16'hF000, 5'b10010);
    run_illegal("ILL_A070", 16'hA070, 5'b10010);
    run_illegal("ILL_0020", 16'h0020, 5'b10010);

    poke(4'd0, 16'hF0F0);
    poke(4'd7, 16'h3C3C);
    run_op("AND", 16'h0017, 16'hF0F0, 16'h3C3C, 1'b1, 16'h3030, 5'b00000);
    check("AND R0", 32'(regs[0]), 32'h3030);

    poke(4'd8, 16'h0010);
    run_op("ADDUI_ZX", 16'h6880, 16'h0010, 16'h0080, 1'b0, 16'h0090, 5'b00000);

    poke(4'd9, 16'h0001);
    run_op("SHI", 16'hA96F, 16'h0001, 16'h000F, 1'b0, 16'h8000, 5'b00000);

    poke(4'd10, 16'hFFFF);
    run_op("ADDUI_C", 16'h6A01, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 5'b10010);

    // Abort mid-EXEC with reset.
    poke(4'd13, 16'h0001);
    poke(4'd14, 16'h0001);
    instr_valid = 1'b1;
    instr       = 16'h0D5E;
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    check("abort alu_a", 32'(alu_a), 32'h0001);
    rst_n = 1'b0;
    #1;
    check("abort busy", 32'(busy), 32'd0);
    check("abort rf_we", 32'(rf_we), 32'd0);
    check("abort psr", 32'(psr), 32'h00);
    check("abort alu_a0", 32'(alu_a), 32'h0);
    check("abort ready", 32'(instr_ready), 32'd1);
    @(negedge clk);
    check("abort no_we", 32'(rf_we), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    check("abort R13", 32'(regs[13]), 32'h0001);
    check("abort ready_rel", 32'(instr_ready), 32'd1);

    // Back-to-back valid is held off until IDLE.
    poke(4'd15, 16'h0002);
    instr_valid = 1'b1;
    instr       = 16'h6F01;
    @(negedge clk);
    instr = 16'h0D5E;
    check("b2b ready_dec", 32'(instr_ready), 32'd0);
    @(negedge clk);
    check("b2b ready_exe", 32'(instr_ready), 32'd0);
    check("b2b alu_a", 32'(alu_a), 32'h0002);
    @(negedge clk);
    check("b2b ready_wb", 32'(instr_ready), 32'd0);
    check("b2b wdata1", 32'(rf_wdata), 32'h0003);
    check("b2b waddr1", 32'(rf_waddr), 32'hF);
    @(negedge clk);
    check("b2b ready_idle", 32'(instr_ready), 32'd1);
    @(negedge clk);
    instr_valid = 1'b0;
    check("b2b raddr_a", 32'(rf_raddr_a), 32'hD);
    check("b2b raddr_b", 32'(rf_raddr_b), 32'hE);
    @(negedge clk);
    @(negedge clk);
    check("b2b we2", 32'(rf_we), 32'd1);
    check("b2b wdata2", 32'(rf_wdata), 32'h0002);
    @(negedge clk);
    check("b2b psr", 32'(psr), 32'h00);
    check("b2b R15", 32'(regs[15]), 32'h0003);
    check("b2b R13", 32'(regs[13]), 32'h0002);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
